// File: rtl/issue_queue_int.sv
// issue_queue_int: integer issue queue between the dispatch register and the ALU.
// Collapsing queue with the oldest entry at index 0. Waiting operands are captured from
// the CDB. The oldest entry with both operands ready is offered to the ALU through a
// valid/ready handshake.
// Optional feature: define ISSUEQ_PERF_CNT_EN to add the 32-bit o_full_stall_cnt output.
module issue_queue_int #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int CTRL_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_disp_valid,
    input  logic              i_disp_rs1_rdy,
    input  logic [TAG_W-1:0]  i_disp_rs1_tag,
    input  logic [DATA_W-1:0] i_disp_rs1_data,
    input  logic              i_disp_rs2_rdy,
    input  logic [TAG_W-1:0]  i_disp_rs2_tag,
    input  logic [DATA_W-1:0] i_disp_rs2_data,
    input  logic [TAG_W-1:0]  i_disp_rd_tag,
    input  logic [CTRL_W-1:0] i_disp_ctrl,
    output logic              o_full,
`ifdef ISSUEQ_PERF_CNT_EN
    output logic [31:0]       o_full_stall_cnt,
`endif
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    output logic              o_issue_valid,
    input  logic              i_issue_ready,
    output logic [DATA_W-1:0] o_issue_rs1_data,
    output logic [DATA_W-1:0] o_issue_rs2_data,
    output logic [TAG_W-1:0]  o_issue_rd_tag,
    output logic [CTRL_W-1:0] o_issue_ctrl
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic              vld;
        logic              rs1_rdy;
        logic [TAG_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs1_data;
        logic              rs2_rdy;
        logic [TAG_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs2_data;
        logic [TAG_W-1:0]  rd_tag;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t          q     [DEPTH];   // registered queue
    entry_t          w     [DEPTH];   // after CDB wake-up
    entry_t          s     [DEPTH];   // after collapse on issue
    entry_t          n     [DEPTH];   // next state
    entry_t          d;               // incoming dispatch entry with bypass applied
    logic [CW-1:0]   count;
    logic [CW-1:0]   n_count;
    logic [CW-1:0]   wr_idx;
    logic [IW-1:0]   sel;
    logic            found;
    logic            fire;
    logic            accept;

    // An operand still waiting on its producer is satisfied by a matching CDB broadcast.
    function automatic logic cdb_hit(input logic vld, input logic rdy,
                                     input logic [TAG_W-1:0] tag, input logic cv,
                                     input logic [TAG_W-1:0] ct);
        cdb_hit = vld & ~rdy & cv & (tag == ct);
    endfunction

    assign o_full = (count == CW'(DEPTH));
    assign fire   = o_issue_valid & i_issue_ready;
    assign accept = i_disp_valid & ~o_full & ~i_flush;
    assign wr_idx = fire ? (count - CW'(1)) : count;

    // Oldest-first select: the lowest index whose operands are both ready.
    always_comb begin
        sel   = {IW{1'b0}};
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            sel   = (q[i].vld & q[i].rs1_rdy & q[i].rs2_rdy) ? i[IW-1:0] : sel;
            found = found | (q[i].vld & q[i].rs1_rdy & q[i].rs2_rdy);
        end
    end

    // Issue outputs come straight from the selected entry; zero when nothing is selectable.
    always_comb begin
        o_issue_valid    = found & ~i_flush;
        o_issue_rs1_data = found ? q[sel].rs1_data : {DATA_W{1'b0}};
        o_issue_rs2_data = found ? q[sel].rs2_data : {DATA_W{1'b0}};
        o_issue_rd_tag   = found ? q[sel].rd_tag   : {TAG_W{1'b0}};
        o_issue_ctrl     = found ? q[sel].ctrl     : {CTRL_W{1'b0}};
    end

    // Next-state: wake-up, then collapse over the issued slot, then dispatch write, then flush.
    always_comb begin
        d.vld      = 1'b1;
        d.rs1_tag  = i_disp_rs1_tag;
        d.rs2_tag  = i_disp_rs2_tag;
        d.rd_tag   = i_disp_rd_tag;
        d.ctrl     = i_disp_ctrl;
        d.rs1_rdy  = i_disp_rs1_rdy |
                     cdb_hit(1'b1, i_disp_rs1_rdy, i_disp_rs1_tag, i_cdb_valid, i_cdb_tag);
        d.rs1_data = cdb_hit(1'b1, i_disp_rs1_rdy, i_disp_rs1_tag, i_cdb_valid, i_cdb_tag) ?
                     i_cdb_data : i_disp_rs1_data;
        d.rs2_rdy  = i_disp_rs2_rdy |
                     cdb_hit(1'b1, i_disp_rs2_rdy, i_disp_rs2_tag, i_cdb_valid, i_cdb_tag);
        d.rs2_data = cdb_hit(1'b1, i_disp_rs2_rdy, i_disp_rs2_tag, i_cdb_valid, i_cdb_tag) ?
                     i_cdb_data : i_disp_rs2_data;

        for (int i = 0; i < DEPTH; i++) begin
            w[i]          = q[i];
            w[i].rs1_rdy  = q[i].rs1_rdy |
                            cdb_hit(q[i].vld, q[i].rs1_rdy, q[i].rs1_tag, i_cdb_valid, i_cdb_tag);
            w[i].rs1_data = cdb_hit(q[i].vld, q[i].rs1_rdy, q[i].rs1_tag, i_cdb_valid, i_cdb_tag) ?
                            i_cdb_data : q[i].rs1_data;
            w[i].rs2_rdy  = q[i].rs2_rdy |
                            cdb_hit(q[i].vld, q[i].rs2_rdy, q[i].rs2_tag, i_cdb_valid, i_cdb_tag);
            w[i].rs2_data = cdb_hit(q[i].vld, q[i].rs2_rdy, q[i].rs2_tag, i_cdb_valid, i_cdb_tag) ?
                            i_cdb_data : q[i].rs2_data;
        end

        for (int i = 0; i < DEPTH - 1; i++) begin
            s[i] = (fire && (i[IW-1:0] >= sel)) ? w[i+1] : w[i];
        end
        s[DEPTH-1]     = w[DEPTH-1];
        s[DEPTH-1].vld = fire ? 1'b0 : w[DEPTH-1].vld;

        for (int i = 0; i < DEPTH; i++) begin
            n[i]     = (accept && (wr_idx == i[CW-1:0])) ? d : s[i];
            n[i].vld = ~i_flush & ((accept && (wr_idx == i[CW-1:0])) | s[i].vld);
        end

        n_count = i_flush ? {CW{1'b0}} : (count + CW'(accept) - CW'(fire));
    end

    // Queue state registers; async reset clears every entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= entry_t'({ENTRY_W{1'b0}});
            end
            count <= {CW{1'b0}};
        end else begin
            q     <= n;
            count <= n_count;
        end
    end

`ifdef ISSUEQ_PERF_CNT_EN
    // Count cycles the dispatcher presents an instruction while the queue is full; wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_full_stall_cnt <= 32'd0;
        end else if (i_disp_valid & o_full) begin
            o_full_stall_cnt <= o_full_stall_cnt + 32'd1;
        end else begin
            o_full_stall_cnt <= o_full_stall_cnt;
        end
    end
`endif

endmodule
